uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receiver stage of the UART core. It converts the external rx line into parallel characters and feeds the RX FIFO.
- Samples at 16× oversampling, qualified by the baud-generator tick.
- Pushes each good character with a one-cycle rx_done_tick, which is wired directly to the FIFO write.
- Reports overrun and framing errors to the status logic.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first (legal 5..9)
STOP_BIT_TICK, 16, oversample ticks spent in the stop bit (16/24/32 = 1/1.5/2 stop bits)
OVERSAMPLE, 16, ticks per bit period; fixed, not to be overridden

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous active-low reset
rx  in  1  external serial line, asynchronous, idle high
tick  in  1  one-clk oversample strobe from baud generator
rx_full  in  1  RX FIFO full
dout  out  DATA_BITS  received character, valid while rx_done_tick=1
rx_done_tick  out  1  one-clk pulse: push dout into FIFO
overrun_error  out  1  sticky: a good frame was dropped because rx_full=1
frame_error  out  1  one-clk pulse: stop bit sampled low
parity_error  out  1  one-clk pulse: parity mismatch (constant 0 without macro)

Behaviour:
- Clock and reset: one clock, clk. Reset is arst_n, asynchronous, active-low.
- Reset values:
  - dout=0, rx_done_tick=0, overrun_error=0, frame_error=0, parity_error=0.
  - State=IDLE, all counters 0, synchronizer flops=1.
- Input synchronization: rx passes through a 2-FF synchronizer; all logic uses the synchronized copy rx_s. This adds 2 clk of latency.
- Counters:
  - s_cnt: tick counter, 5 bits, advances only on tick=1.
  - n_cnt: bit counter, $clog2(DATA_BITS) bits.
- State machine:
  - IDLE: on rx_s=0, go to START with s_cnt=0. No tick is needed to leave IDLE.
  - START: on tick, when s_cnt==7 (bit centre):
    - rx_s=0: go to DATA with s_cnt=0, n_cnt=0.
    - rx_s=1: glitch; return to IDLE with no outputs.
    - Otherwise s_cnt++.
  - DATA: on tick, when s_cnt==15:
    - Shift rx_s into the MSB of the shift register (right shift), then s_cnt=0.
    - If n_cnt==DATA_BITS-1, go to PARITY (macro on) or STOP; otherwise n_cnt++.
  - PARITY (macro only): on tick, when s_cnt==15, sample the parity bit and go to STOP with s_cnt=0.
  - STOP: on tick, when s_cnt==STOP_BIT_TICK-1, evaluate the frame and go to IDLE. The evaluation, in priority order:
    1. rx_s=0: frame_error pulses; no push.
    2. Parity mismatch: parity_error pulses; no push.
    3. rx_full=1: overrun_error set; no push.
    4. Otherwise: rx_done_tick pulses, dout updated, overrun_error cleared.
- Output timing: all outputs are registered. rx_done_tick and dout appear the clk after the STOP evaluation.
- dout holds its last value until the next push.
- After a frame error, IDLE re-arms only after rx_s has been seen high once (break condition). A continuous low line therefore produces no repeated frames.
- Tick handling:
  - tick=0 freezes every counter; state is held.
  - tick on every clk is legal (dvsr=0).
- Reset mid-frame: immediate return to IDLE with no partial push.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state and one parity bit after the data bits; the frame is 1 + DATA_BITS + 1 + stop bits.
  - Parity is even: XOR of data bits and parity bit must be 0.
  - parity_error is driven as described in Behaviour.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - parity_error is tied to 0.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}, 3 bits. PARITY is always present in the enum.
  - localparam OVERSAMPLE=16.
  - localparam START_MID=7.
- One sub-module: sync_2ff. Generic single-bit 2-flop synchronizer with a reset-value parameter (1 here), reusable for other MMIO inputs.

Test Plan:
- Nominal frame, tick every clk: send 0xA5 (8N1, 16 ticks/bit) → exactly one rx_done_tick, dout=0xA5, no error flags; then back-to-back 0x3C → second push with dout=0x3C.
- Glitch rejection: rx low for 4 ticks, then high → no rx_done_tick and the FSM returns to IDLE; a following 0x5A frame is received correctly.
- Frame error: send 0xFF with the stop bit driven 0 → frame_error pulses for 1 clk, no push; no new frame is accepted until rx returns high.
- Overrun: hold rx_full=1 and send 0x12 → no rx_done_tick, overrun_error=1 and stays 1; drop rx_full and send 0x34 → push dout=0x34 and overrun_error clears.
- Reset mid-frame: assert arst_n=0 during data bit 4 of 0x81 → all outputs 0 at once; after release, a fresh 0x81 is received correctly. Also run with tick every 5 clk and STOP_BIT_TICK=32 and confirm identical data.
- Parity (macro defined): send 0x03 with parity 0 → push; send 0x03 with parity 1 → parity_error pulse and no push.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Optional parity support is selected with the UART_RX_PARITY_EN macro (see uart_rx.sv).
package uart_pkg;

   // Ticks per bit period; fixed by the baud generator and not overridden.
   localparam int unsigned OVERSAMPLE = 16;

   // Tick count at which the start bit is sampled at its centre.
   localparam int unsigned START_MID = 7;

   // PARITY stays in the encoding even when parity is compiled out so the
   // state encoding is identical across builds.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: line, tick and FIFO/status signals of the UART receiver.
// master = environment (line, baud tick, FIFO), slave = the receiver itself.
interface uart_rx_if #(
   parameter int unsigned DATA_BITS = 8
);

   logic                 rx;
   logic                 tick;
   logic                 rx_full;
   logic [DATA_BITS-1:0] dout;
   logic                 rx_done_tick;
   logic                 overrun_error;
   logic                 frame_error;
   logic                 parity_error;

   modport master (
      output rx, tick, rx_full,
      input  dout, rx_done_tick, overrun_error, frame_error, parity_error
   );

   modport slave (
      input  rx, tick, rx_full,
      output dout, rx_done_tick, overrun_error, frame_error, parity_error
   );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: generic single-bit two-flop synchronizer with a configurable reset value.
module sync_2ff #(
   parameter bit RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of an asynchronous input.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver feeding the RX FIFO.
// Define UART_RX_PARITY_EN to add one even-parity bit after the data bits.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned STOP_BIT_TICK = 16
) (
   input  logic      clk,
   input  logic      arst_n,
   uart_rx_if.slave  rx_if
);

   localparam int unsigned NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [NW-1:0] LAST_BIT  = NW'(DATA_BITS - 1);
   localparam logic [4:0]    START_END = 5'(START_MID);
   localparam logic [4:0]    BIT_END   = 5'(OVERSAMPLE - 1);
   localparam logic [4:0]    STOP_END  = 5'(STOP_BIT_TICK - 1);

   logic rx_s;

   rx_state_t            state_q, state_d;
   logic [4:0]           s_cnt_q, s_cnt_d;
   logic [NW-1:0]        n_cnt_q, n_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 brk_q, brk_d;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic                 done_q, done_d;
   logic                 ovr_q, ovr_d;
   logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d;
   logic                 perr_q, perr_d;
`endif

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk_i  (clk),
      .rst_ni (arst_n),
      .d_i    (rx_if.rx),
      .q_o    (rx_s)
   );

   // Next-state: frame sequencing, bit sampling and frame evaluation.
   always_comb begin
      state_d = state_q;
      s_cnt_d = s_cnt_q;
      n_cnt_d = n_cnt_q;
      shreg_d = shreg_q;
      brk_d   = brk_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      ovr_d   = ovr_q;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            // After a framing error the line must go high once before re-arming,
            // so a held break does not spin out a stream of bogus frames.
            if (brk_q) begin
               if (rx_s) begin
                  brk_d = 1'b0;
               end
            end else if (!rx_s) begin
               state_d = START;
               s_cnt_d = '0;
            end
         end
         START: begin
            if (rx_if.tick) begin
               if (s_cnt_q == START_END) begin
                  if (!rx_s) begin
                     state_d = DATA;
                     s_cnt_d = '0;
                     n_cnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 5'd1;
               end
            end
         end
         DATA: begin
            if (rx_if.tick) begin
               if (s_cnt_q == BIT_END) begin
                  shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                  s_cnt_d = '0;
                  if (n_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     n_cnt_d = n_cnt_q + 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 5'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (rx_if.tick) begin
               if (s_cnt_q == BIT_END) begin
                  par_d   = rx_s;
                  state_d = STOP;
                  s_cnt_d = '0;
               end else begin
                  s_cnt_d = s_cnt_q + 5'd1;
               end
            end
         end
`endif
         STOP: begin
            if (rx_if.tick) begin
               if (s_cnt_q == STOP_END) begin
                  state_d = IDLE;
                  s_cnt_d = '0;
                  // Error priority: framing, then parity, then overrun.
                  if (!rx_s) begin
                     ferr_d = 1'b1;
                     brk_d  = 1'b1;
                  end
`ifdef UART_RX_PARITY_EN
                  else if (^{shreg_q, par_q}) begin
                     perr_d = 1'b1;
                  end
`endif
                  else if (rx_if.rx_full) begin
                     ovr_d = 1'b1;
                  end else begin
                     done_d = 1'b1;
                     dout_d = shreg_q;
                     ovr_d  = 1'b0;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 5'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            s_cnt_d = '0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= IDLE;
         s_cnt_q <= '0;
         n_cnt_q <= '0;
         shreg_q <= '0;
         brk_q   <= 1'b0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_cnt_q <= s_cnt_d;
         n_cnt_q <= n_cnt_d;
         shreg_q <= shreg_d;
         brk_q   <= brk_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign rx_if.dout          = dout_q;
   assign rx_if.rx_done_tick  = done_q;
   assign rx_if.overrun_error = ovr_q;
   assign rx_if.frame_error   = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign rx_if.parity_error  = perr_q;
`else
   assign rx_if.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (8 data bits).
// Instance a: STOP_BIT_TICK=16, tick every clk. Instance b: STOP_BIT_TICK=32, tick every 5 clk.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int unsigned DW = 8;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   uart_rx_if #(.DATA_BITS(DW)) if_a ();
   uart_rx_if #(.DATA_BITS(DW)) if_b ();

   uart_rx #(.DATA_BITS(DW), .STOP_BIT_TICK(16)) dut_a (
      .clk    (clk),
      .arst_n (arst_n),
      .rx_if  (if_a)
   );

   uart_rx #(.DATA_BITS(DW), .STOP_BIT_TICK(32)) dut_b (
      .clk    (clk),
      .arst_n (arst_n),
      .rx_if  (if_b)
   );

   // Baud tick for instance b: one clk in five.
   int tdiv_b = 0;
   always @(negedge clk) begin
      if_b.tick = (tdiv_b == 4);
      tdiv_b    = (tdiv_b == 4) ? 0 : tdiv_b + 1;
   end

   // Event monitors, sampled mid-cycle.
   int            done_a = 0;
   int            done_b = 0;
   int            ferr_a = 0;
   int            perr_a = 0;
   logic [DW-1:0] dout_a = '0;
   logic [DW-1:0] dout_b = '0;
   always @(negedge clk) begin
      if (if_a.rx_done_tick === 1'b1) begin
         done_a <= done_a + 1;
         dout_a <= if_a.dout;
      end
      if (if_a.frame_error === 1'b1)  ferr_a <= ferr_a + 1;
      if (if_a.parity_error === 1'b1) perr_a <= perr_a + 1;
      if (if_b.rx_done_tick === 1'b1) begin
         done_b <= done_b + 1;
         dout_b <= if_b.dout;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic set_rx(input bit slow, input logic v);
      if (slow) if_b.rx = v;
      else      if_a.rx = v;
   endtask

   // Wait n baud ticks of the selected instance; returns 1 time unit after a posedge.
   task automatic wait_ticks(input bit slow, input int n);
      int k = 0;
      while (k < n) begin
         @(posedge clk);
         if (slow ? if_b.tick : if_a.tick) k++;
      end
      #1;
   endtask

   // Start, data LSB first, optional even parity (flipped on request), stop.
   // The line is left at stop_val.
   task automatic send_frame(input bit slow, input logic [DW-1:0] data, input logic stop_val,
                             input logic par_flip, input int stop_ticks);
      logic [DW+1:0] bits;
      int            nbits;
      bits = {(^data) ^ par_flip, data, 1'b0};
`ifdef UART_RX_PARITY_EN
      nbits = DW + 2;
`else
      nbits = DW + 1;
`endif
      for (int i = 0; i < nbits; i++) begin
         set_rx(slow, bits[i]);
         wait_ticks(slow, 16);
      end
      set_rx(slow, stop_val);
      wait_ticks(slow, stop_ticks);
   endtask

   task automatic test_reset();
      if_a.rx = 1'b1; if_a.tick = 1'b1; if_a.rx_full = 1'b0;
      if_b.rx = 1'b1; if_b.tick = 1'b0; if_b.rx_full = 1'b0;
      arst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      arst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (if_a.dout !== 8'h00) begin
         errors++; $display("FAIL reset_dout: got %h want 00", if_a.dout); end
      checks++; if (if_a.rx_done_tick !== 1'b0) begin
         errors++; $display("FAIL reset_done: got %b want 0", if_a.rx_done_tick); end
      checks++; if (if_a.overrun_error !== 1'b0) begin
         errors++; $display("FAIL reset_overrun: got %b want 0", if_a.overrun_error); end
      checks++; if (if_a.frame_error !== 1'b0) begin
         errors++; $display("FAIL reset_frame: got %b want 0", if_a.frame_error); end
      checks++; if (if_a.parity_error !== 1'b0) begin
         errors++; $display("FAIL reset_parity: got %b want 0", if_a.parity_error); end
   endtask

   task automatic test_nominal();
      int d0 = done_a;
      int f0 = ferr_a;
      send_frame(0, 8'hA5, 1'b1, 1'b0, 16);
      checks++; if (done_a !== d0 + 1) begin
         errors++; $display("FAIL nominal_count: got %0d want %0d", done_a, d0 + 1); end
      checks++; if (dout_a !== 8'hA5) begin
         errors++; $display("FAIL nominal_dout: got %h want a5", dout_a); end
      // Next frame starts immediately.
      send_frame(0, 8'h3C, 1'b1, 1'b0, 16);
      wait_ticks(0, 20);
      checks++; if (done_a !== d0 + 2) begin
         errors++; $display("FAIL b2b_count: got %0d want %0d", done_a, d0 + 2); end
      checks++; if (dout_a !== 8'h3C) begin
         errors++; $display("FAIL b2b_dout: got %h want 3c", dout_a); end
      checks++; if (ferr_a !== f0 || if_a.overrun_error !== 1'b0) begin
         errors++; $display("FAIL nominal_flags: got ferr %0d ovr %b want %0d 0",
                            ferr_a, if_a.overrun_error, f0); end
   endtask

   task automatic test_glitch();
      int d0 = done_a;
      set_rx(0, 1'b0);
      wait_ticks(0, 4);
      set_rx(0, 1'b1);
      wait_ticks(0, 30);
      checks++; if (done_a !== d0) begin
         errors++; $display("FAIL glitch_nopush: got %0d want %0d", done_a, d0); end
      checks++; if (dut_a.state_q !== IDLE) begin
         errors++; $display("FAIL glitch_idle: got %0d want %0d", dut_a.state_q, IDLE); end
      send_frame(0, 8'h5A, 1'b1, 1'b0, 16);
      wait_ticks(0, 20);
      checks++; if (done_a !== d0 + 1 || dout_a !== 8'h5A) begin
         errors++; $display("FAIL glitch_next: got %0d/%h want %0d/5a", done_a, dout_a, d0 + 1); end
   endtask

   task automatic test_frame_error();
      int d0 = done_a;
      int f0 = ferr_a;
      send_frame(0, 8'hFF, 1'b0, 1'b0, 16);
      // Hold a break: must not be taken as further frames.
      wait_ticks(0, 400);
      checks++; if (ferr_a !== f0 + 1) begin
         errors++; $display("FAIL ferr_pulse: got %0d cycles want %0d", ferr_a, f0 + 1); end
      checks++; if (done_a !== d0) begin
         errors++; $display("FAIL ferr_nopush: got %0d want %0d", done_a, d0); end
      set_rx(0, 1'b1);
      wait_ticks(0, 20);
      send_frame(0, 8'hC3, 1'b1, 1'b0, 16);
      wait_ticks(0, 20);
      checks++; if (done_a !== d0 + 1 || dout_a !== 8'hC3) begin
         errors++; $display("FAIL ferr_recover: got %0d/%h want %0d/c3", done_a, dout_a, d0 + 1); end
   endtask

   task automatic test_overrun();
      int d0 = done_a;
      if_a.rx_full = 1'b1;
      send_frame(0, 8'h12, 1'b1, 1'b0, 16);
      wait_ticks(0, 50);
      checks++; if (done_a !== d0) begin
         errors++; $display("FAIL ovr_nopush: got %0d want %0d", done_a, d0); end
      if_a.rx_full = 1'b0;
      wait_ticks(0, 50);
      checks++; if (if_a.overrun_error !== 1'b1) begin
         errors++; $display("FAIL ovr_sticky: got %b want 1", if_a.overrun_error); end
      send_frame(0, 8'h34, 1'b1, 1'b0, 16);
      wait_ticks(0, 20);
      checks++; if (done_a !== d0 + 1 || dout_a !== 8'h34) begin
         errors++; $display("FAIL ovr_push: got %0d/%h want %0d/34", done_a, dout_a, d0 + 1); end
      checks++; if (if_a.overrun_error !== 1'b0) begin
         errors++; $display("FAIL ovr_clear: got %b want 0", if_a.overrun_error); end
   endtask

   task automatic test_reset_mid_frame();
      logic [DW-1:0] v = 8'h81;
      int            d0;
      // Set overrun again so the reset has something to clear.
      if_a.rx_full = 1'b1;
      send_frame(0, 8'h55, 1'b1, 1'b0, 16);
      if_a.rx_full = 1'b0;
      wait_ticks(0, 10);
      d0 = done_a;
      set_rx(0, 1'b0);
      wait_ticks(0, 16);
      for (int i = 0; i < 4; i++) begin
         set_rx(0, v[i]);
         wait_ticks(0, 16);
      end
      set_rx(0, v[4]);
      wait_ticks(0, 8);
      arst_n = 1'b0;
      #1;
      checks++; if (if_a.dout !== 8'h00 || if_a.overrun_error !== 1'b0) begin
         errors++; $display("FAIL midrst_out: got %h/%b want 00/0", if_a.dout, if_a.overrun_error); end
      checks++; if (dut_a.state_q !== IDLE) begin
         errors++; $display("FAIL midrst_idle: got %0d want %0d", dut_a.state_q, IDLE); end
      set_rx(0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      arst_n = 1'b1;
      wait_ticks(0, 30);
      checks++; if (done_a !== d0) begin
         errors++; $display("FAIL midrst_nopush: got %0d want %0d", done_a, d0); end
      send_frame(0, v, 1'b1, 1'b0, 16);
      wait_ticks(0, 20);
      checks++; if (done_a !== d0 + 1 || dout_a !== 8'h81) begin
         errors++; $display("FAIL midrst_fresh: got %0d/%h want %0d/81", done_a, dout_a, d0 + 1); end
   endtask

   task automatic test_slow_tick();
      int d0 = done_b;
      send_frame(1, 8'h81, 1'b1, 1'b0, 32);
      wait_ticks(1, 20);
      checks++; if (done_b !== d0 + 1 || dout_b !== 8'h81) begin
         errors++; $display("FAIL slow_81: got %0d/%h want %0d/81", done_b, dout_b, d0 + 1); end
      send_frame(1, 8'hA5, 1'b1, 1'b0, 32);
      wait_ticks(1, 20);
      checks++; if (done_b !== d0 + 2 || dout_b !== 8'hA5) begin
         errors++; $display("FAIL slow_a5: got %0d/%h want %0d/a5", done_b, dout_b, d0 + 2); end
      checks++; if (if_b.frame_error !== 1'b0 || if_b.overrun_error !== 1'b0) begin
         errors++; $display("FAIL slow_flags: got %b/%b want 0/0",
                            if_b.frame_error, if_b.overrun_error); end
   endtask

   task automatic test_parity();
      int d0 = done_a;
      int p0 = perr_a;
`ifdef UART_RX_PARITY_EN
      send_frame(0, 8'h03, 1'b1, 1'b0, 16);
      wait_ticks(0, 20);
      checks++; if (done_a !== d0 + 1 || dout_a !== 8'h03 || perr_a !== p0) begin
         errors++; $display("FAIL parity_good: got %0d/%h/%0d want %0d/03/%0d",
                            done_a, dout_a, perr_a, d0 + 1, p0); end
      send_frame(0, 8'h03, 1'b1, 1'b1, 16);
      wait_ticks(0, 20);
      checks++; if (perr_a !== p0 + 1) begin
         errors++; $display("FAIL parity_bad: got %0d want %0d", perr_a, p0 + 1); end
      checks++; if (done_a !== d0 + 1) begin
         errors++; $display("FAIL parity_nopush: got %0d want %0d", done_a, d0 + 1); end
`else
      send_frame(0, 8'h07, 1'b1, 1'b0, 16);
      wait_ticks(0, 20);
      checks++; if (done_a !== d0 + 1 || dout_a !== 8'h07) begin
         errors++; $display("FAIL noparity_push: got %0d/%h want %0d/07", done_a, dout_a, d0 + 1); end
      checks++; if (perr_a !== 0 || p0 !== 0) begin
         errors++; $display("FAIL noparity_flag: got %0d want 0", perr_a); end
`endif
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_reset_mid_frame();
      test_slow_tick();
      test_parity();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
